// File: rtl/uart_rx.sv
// Oversampling UART receiver: start detect, centre-sampled data, stop check; optional even parity via UART_RX_PARITY_EN.
// Latency: NB_STOP/2 + (NB_DATA+1)*NB_STOP ticks (+NB_STOP with parity) plus 2 clk from line fall to o_rxdone.
// Backpressure: none; each frame result is a single-cycle strobe that must be captured when it appears.
module uart_rx #(
    parameter int NB_DATA = 8,
    parameter int NB_STOP = 16
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rxdone,
    output logic               o_frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic               o_parity_err
`endif
);

    localparam int TW = (NB_STOP > 2) ? $clog2(NB_STOP) : 1;
    localparam int BW = (NB_DATA > 2) ? $clog2(NB_DATA) : 1;
    localparam logic [TW-1:0] TICK_HALF = TW'(NB_STOP / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(NB_STOP - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(NB_DATA - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [4:0] {
        S_IDLE   = 5'b00001,
        S_START  = 5'b00010,
        S_DATA   = 5'b00100,
        S_PARITY = 5'b01000,
        S_STOP   = 5'b10000
    } state_t;
`else
    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_START = 4'b0010,
        S_DATA  = 4'b0100,
        S_STOP  = 4'b1000
    } state_t;
`endif

    state_t               state_q, state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [NB_DATA-1:0]   shift_q, shift_d;
    logic [NB_DATA-1:0]   data_q, data_d;
    logic                 rxdone_q, rxdone_d;
    logic                 frame_err_q, frame_err_d;
    logic                 rx_q, rx_prev_q, armed_q;
    logic                 fall;
`ifdef UART_RX_PARITY_EN
    logic                 par_q, par_d;
    logic                 parity_err_q, parity_err_d;
`endif

    // armed_q keeps a line that is already low out of reset from looking like a start edge
    assign fall = armed_q & rx_prev_q & ~rx_q;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            rxdone_q    <= 1'b0;
            frame_err_q <= 1'b0;
            rx_q        <= 1'b1;
            rx_prev_q   <= 1'b1;
            armed_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            rxdone_q    <= rxdone_d;
            frame_err_q <= frame_err_d;
            rx_q        <= i_rx;
            rx_prev_q   <= rx_q;
            armed_q     <= armed_q | i_rx;
`ifdef UART_RX_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        rxdone_d    = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    state_d    = S_START;
                    tick_cnt_d = '0;
                end
            end
            S_START: begin
                if (i_tick) begin
                    if (tick_cnt_q == TICK_HALF) begin
                        if (!rx_q) begin
                            state_d    = S_DATA;
                            tick_cnt_d = '0;
                            bit_cnt_d  = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end
            S_DATA: begin
                if (i_tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        shift_d    = {rx_q, shift_q[NB_DATA-1:1]};
                        tick_cnt_d = '0;
                        if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + BW'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (i_tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        par_d      = rx_q;
                        tick_cnt_d = '0;
                        state_d    = S_STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end
`endif
            S_STOP: begin
                if (i_tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        // an edge coinciding with frame completion must not be lost
                        state_d    = fall ? S_START : S_IDLE;
                        if (!rx_q) begin
                            frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (^{shift_q, par_q}) begin
                            parity_err_d = 1'b1;
`endif
                        end else begin
                            data_d   = shift_q;
                            rxdone_d = 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_data      = data_q;
    assign o_rxdone    = rxdone_q;
    assign o_frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed and random frames driven on a tick-aligned bit grid, checked against a frame-level event model.
module tb_uart_rx;

    localparam int NBD = 8;
    localparam int NBS = 16;
    localparam int DIV = 4;
`ifdef UART_RX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int LAT = NBS / 2 + (NBD + 1 + PBITS) * NBS;

    typedef struct {
        int         kind;   // 1 = byte received, 2 = framing error, 3 = parity error
        logic [7:0] data;
        int         tick;
    } ev_t;

    logic       clk = 1'b0;
    logic       i_rst;
    logic       i_tick;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_rxdone;
    logic       o_frame_err;
    logic       o_parity_err;

    int  n_assert = 0;
    int  n_fail   = 0;
    int  tick_count = 0;
    int  ph;
    ev_t obs_q[$];
    ev_t exp_q[$];
    logic [7:0] m_data;
    logic prev_done = 1'b0, prev_ferr = 1'b0, prev_perr = 1'b0;

    always #5 clk = ~clk;

    uart_rx #(.NB_DATA(NBD), .NB_STOP(NBS)) dut (
        .clk         (clk),
        .i_rst       (i_rst),
        .i_tick      (i_tick),
        .i_rx        (i_rx),
        .o_data      (o_data),
        .o_rxdone    (o_rxdone),
        .o_frame_err (o_frame_err)
`ifdef UART_RX_PARITY_EN
        ,
        .o_parity_err(o_parity_err)
`endif
    );

`ifndef UART_RX_PARITY_EN
    assign o_parity_err = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        i_tick = 1'b0;
        ph = 0;
        forever begin
            @(negedge clk);
            ph = (ph + 1) % DIV;
            i_tick = (ph == 0);
        end
    end

    always @(posedge clk) if (i_tick) tick_count <= tick_count + 1;

    // record every strobe with the tick count at which it became visible
    always @(negedge clk) begin
        if (o_rxdone || o_frame_err || o_parity_err) begin
            ev_t e;
            chk("strobe_exclusive", 32'(o_rxdone) + 32'(o_frame_err) + 32'(o_parity_err), 32'd1);
            chk("strobe_one_cycle", {29'd0, prev_done & o_rxdone, prev_ferr & o_frame_err,
                                     prev_perr & o_parity_err}, 32'd0);
            e.kind = o_rxdone ? 1 : (o_frame_err ? 2 : 3);
            e.data = o_data;
            e.tick = tick_count;
            obs_q.push_back(e);
        end
        prev_done <= o_rxdone;
        prev_ferr <= o_frame_err;
        prev_perr <= o_parity_err;
    end

    task automatic wait_ticks(input int n);
        int t;
        t = tick_count + n;
        while (tick_count < t) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        i_rx = b;
        wait_ticks(NBS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        ev_t e;
        e.tick = tick_count + LAT;
        if (!stop_b) begin
            e.kind = 2;
            e.data = m_data;
        end else if ((PBITS == 1) && (par_b != ^d)) begin
            e.kind = 3;
            e.data = m_data;
        end else begin
            e.kind = 1;
            e.data = d;
            m_data = d;
        end
        exp_q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < NBD; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_b);
`endif
        drive_bit(stop_b);
    endtask

    task automatic check_events(input string tag);
        int n;
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_kind"}, obs_q[i].kind, exp_q[i].kind);
            chk({tag, "_data"}, {24'd0, obs_q[i].data}, {24'd0, exp_q[i].data});
            chk({tag, "_tick"}, obs_q[i].tick, exp_q[i].tick);
        end
        obs_q.delete();
        exp_q.delete();
        chk({tag, "_held"}, {24'd0, o_data}, {24'd0, m_data});
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, failures so far %0d", n_fail);
        $fatal(1, "time limit");
    end

    initial begin
        logic [7:0] d;
        logic       s_ok, p_b;
        int         gap;

        m_data = 8'h00;
        i_rx   = 1'b0;
        i_rst  = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset_data", {24'd0, o_data}, 32'd0);
        chk("reset_rxdone", {31'd0, o_rxdone}, 32'd0);
        chk("reset_frame_err", {31'd0, o_frame_err}, 32'd0);
        chk("reset_parity_err", {31'd0, o_parity_err}, 32'd0);
        i_rst = 1'b0;

        // line low out of reset: nothing may start
        wait_ticks(200);
        check_events("low_after_reset");
        i_rx = 1'b1;
        wait_ticks(20);

        send_frame(8'hA5, 1'b1, ^8'hA5);
        check_events("byte_a5");
        for (int k = 0; k < 4; k++) begin
            d = 8'($urandom);
            send_frame(d, 1'b1, ^d);
        end
        check_events("random_good");

        i_rx = 1'b0;
        wait_ticks(5);
        i_rx = 1'b1;
        wait_ticks(40);
        check_events("glitch");

        send_frame(8'h3C, 1'b0, ^8'h3C);
        i_rx = 1'b0;
        wait_ticks(300);
        i_rx = 1'b1;
        wait_ticks(20);
        check_events("break");

        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h81, 1'b1, 1'b0);
        check_events("back_to_back");

        // abort 0x55 partway through its data bits
        i_rx = 1'b0;
        wait_ticks(NBS);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        i_rst = 1'b1;
        i_rx  = 1'b1;
        repeat (3) @(negedge clk);
        chk("midreset_data", {24'd0, o_data}, 32'd0);
        i_rst = 1'b0;
        m_data = 8'h00;
        wait_ticks(40);
        send_frame(8'h12, 1'b1, ^8'h12);
        wait_ticks(10);
        check_events("reset_abort");

        for (int k = 0; k < 8; k++) begin
            d    = 8'($urandom);
            s_ok = ($urandom_range(0, 3) != 0);
            p_b  = (^d) ^ (PBITS == 1 && $urandom_range(0, 3) == 0);
            gap  = $urandom_range(0, 3);
            if (!s_ok && gap == 0) gap = 1;
            send_frame(d, s_ok, p_b);
            if (gap > 0) begin
                i_rx = 1'b1;
                wait_ticks(gap);
            end
        end
        i_rx = 1'b1;
        wait_ticks(10);
        check_events("random_mix");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        send_frame(8'h07, 1'b1, 1'b0);
        wait_ticks(5);
        check_events("parity");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Oversampling UART receiver: the receive half of the board's serial link, paired with the existing transmitter and the shared baud-rate tick generator. It detects a start bit on the serial line, samples each data bit at its centre using `i_tick` (NB_STOP ticks per bit), and checks the stop bit. It presents the received byte with a one-cycle done strobe, or flags a framing error.

## Interface
- `NB_DATA`, 8 — data bits per frame, sent LSB first.
- `NB_STOP`, 16 — baud ticks per bit period (oversampling factor). Must be even and ≥ 4.
- `clk`  in  1 — system clock; all logic is on its rising edge.
- `i_rst`  in  1 — reset, asynchronous, active-high.
- `i_tick`  in  1 — baud oversampling strobe, one `clk` wide, at NB_STOP × baud rate.
- `i_rx`  in  1 — serial line; idles high.
- `o_data`  out  NB_DATA — last correctly framed byte; held until the next good frame.
- `o_rxdone`  out  1 — one-cycle pulse when `o_data` updates.
- `o_frame_err`  out  1 — one-cycle pulse when the stop bit is sampled low.
- `o_parity_err`  out  1 — present only with `UART_RX_PARITY_EN` (see Configuration).

## Operation
- Counters:
  - tick counter is clogb2(NB_STOP-1) bits wide;
  - bit counter is clogb2(NB_DATA-1) bits wide;
  - both wrap only by explicit clear, never by overflow.
- `i_rx` is registered once into `rx_q`, and `rx_prev` holds the prior `rx_q`. Start detection uses the falling edge (`rx_prev`=1, `rx_q`=0).
- **IDLE**: on a falling edge → START, tick counter cleared. Ticks are ignored. A line that is low straight out of reset does not start a frame.
- **START**: on each tick the counter increments. When counter == NB_STOP/2−1 (mid start bit):
  - `rx_q`=0 → DATA, counter and bit counter cleared;
  - `rx_q`=1 → glitch, return to IDLE with no outputs.
- **DATA**: on each tick the counter increments. When counter == NB_STOP−1:
  - shift register ← {`rx_q`, shift[NB_DATA-1:1]} (LSB first);
  - counter cleared;
  - after the NB_DATA-th bit → STOP (or PARITY, if enabled); otherwise the bit counter increments.
- **STOP**: when counter == NB_STOP−1 on a tick, `rx_q` is sampled:
  - `rx_q`=1 → `o_data` ← shift register, `o_rxdone` pulses;
  - `rx_q`=0 → `o_frame_err` pulses, `o_data` unchanged;
  - either way → IDLE.
- A break (line held low) gives exactly one framing error. No new frame starts until the line goes high, then falls again.
- The state encoding is one-hot, and an illegal state returns to IDLE on the next clock.
- Without `i_tick`, every state holds and the counters freeze.

## Timing
- Reset values:
  - `o_data`=0, `o_rxdone`=0, `o_frame_err`=0, `o_parity_err`=0;
  - state IDLE;
  - counters 0, shift register 0;
  - `rx_q`=1, `rx_prev`=1.
- Reset mid-frame aborts at once; no strobe follows.
- Latency from the line's falling edge to the `o_rxdone` rising edge:
  - NB_STOP/2 + (NB_DATA+1)·NB_STOP ticks, plus 2 `clk` (input register, then output register);
  - for the defaults this is 152 ticks.
- `o_rxdone` and `o_frame_err` are registered, are never high together, and each is high for exactly one `clk`.
- A falling edge in the same `clk` as the STOP→IDLE transition is detected on the next cycle, so back-to-back frames are accepted. The receiver re-arms half a bit before the nominal end of the stop bit.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - a PARITY state between DATA and STOP samples one even-parity bit at counter == NB_STOP−1;
  - a mismatch pulses `o_parity_err` in the same cycle the frame completes and suppresses the `o_data` update and `o_rxdone`;
  - a framing error takes precedence: it is reported alone and `o_parity_err` stays 0;
  - latency grows by NB_STOP ticks.
- Not defined: no PARITY state, and the `o_parity_err` port is absent.

## Test plan
- Reset, then `i_tick` every 4 `clk`; send 0xA5 with a good stop bit → `o_data`=0xA5, `o_rxdone` high 1 cycle at 152 ticks + 2 clk, `o_frame_err`=0.
- `i_rx` low for 5 ticks, then high → no strobe, state back to IDLE, `o_data` unchanged.
- Send 0x3C with the stop bit forced low → `o_frame_err` pulses once, `o_data` keeps its prior value; line held low afterwards → no further strobes until it rises.
- Back-to-back 0x00, 0xFF, 0x81 with no idle gap → three `o_rxdone` pulses 160 ticks apart, with `o_data` equal to each byte in turn.
- Assert `i_rst` mid-DATA of 0x55, release, then send 0x12 → only one `o_rxdone`, with `o_data`=0x12.
- With `UART_RX_PARITY_EN`: send 0x07 with parity 1 → `o_rxdone`; send 0x07 with parity 0 → `o_parity_err` pulse, no `o_rxdone`.
